pos_update_scheduler: RTL



---
 rtl/pos_update_scheduler_if.sv | 19 +
 rtl/pos_update_scheduler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pos_update_scheduler_if.sv
// Bus between the position update scheduler and the shared bounded-next-position datapath.
interface pos_update_scheduler_if #(
    parameter int POS_LOG_SIZE = 10
);
    logic                    dp_dir;
    logic [POS_LOG_SIZE-1:0] dp_speed;
    logic [POS_LOG_SIZE-1:0] dp_boundary;
    logic [POS_LOG_SIZE-1:0] dp_currentPos;
    logic [POS_LOG_SIZE-1:0] dp_boundedNextPos;

    modport master (
        output dp_dir, dp_speed, dp_boundary, dp_currentPos,
        input  dp_boundedNextPos
    );
    modport slave (
        input  dp_dir, dp_speed, dp_boundary, dp_currentPos,
        output dp_boundedNextPos
    );
endinterface

// File: rtl/pos_update_scheduler.sv
// Time-multiplexes the shared bounded-next-position datapath across NUM_OBJ objects per frame tick.
// Optional macro POS_SCHED_LOAD_EN adds a direct position load port used while idle.
module pos_update_scheduler #(
    parameter int                    POS_LOG_SIZE = 10,
    parameter int                    NUM_OBJ      = 4,
    parameter int                    PIPE_LAT     = 2,
    parameter logic [POS_LOG_SIZE-1:0] INIT_POS   = '0,
    localparam int                   IDX_W        = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            frame_tick,
    input  logic [NUM_OBJ*POS_LOG_SIZE-1:0] obj_speed,
    input  logic [NUM_OBJ-1:0]              obj_dir,
    input  logic [NUM_OBJ*POS_LOG_SIZE-1:0] obj_boundary,
    output logic [NUM_OBJ*POS_LOG_SIZE-1:0] obj_pos,
    output logic [NUM_OBJ-1:0]              obj_hit,
    output logic                            busy,
    output logic                            done,
    output logic                            overrun,
`ifdef POS_SCHED_LOAD_EN
    input  logic                            load_valid,
    input  logic [IDX_W-1:0]                load_idx,
    input  logic [POS_LOG_SIZE-1:0]         load_pos,
    output logic                            load_ready,
`endif
    pos_update_scheduler_if.master          dp
);
    typedef logic [POS_LOG_SIZE-1:0] pos_t;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                       state_q, state_d;
    pos_t [NUM_OBJ-1:0]           pos_q, spd_a, bnd_a;
    logic [NUM_OBJ-1:0]           hit_q;
    logic                         overrun_q;
    logic [IDX_W-1:0]             issue_idx;
    logic                         issuing, last_issue, last_wb, tick_idle;
    logic [PIPE_LAT:1]            vld_pipe;
    logic [PIPE_LAT:1][IDX_W-1:0] idx_pipe;
    pos_t [PIPE_LAT:1]            bnd_pipe;

    assign spd_a      = obj_speed;
    assign bnd_a      = obj_boundary;
    assign obj_pos    = pos_q;
    assign obj_hit    = hit_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign tick_idle  = (state_q == IDLE) && frame_tick;
    assign last_issue = (issue_idx == IDX_W'(NUM_OBJ - 1));
`ifdef POS_SCHED_LOAD_EN
    assign load_ready = (state_q == IDLE) && !frame_tick;
`endif

    // Round ends on the writeback of the final issue: oldest stage full, all younger empty.
    always_comb begin
        last_wb = vld_pipe[PIPE_LAT];
        for (int i = 1; i < PIPE_LAT; i++)
            if (vld_pipe[i]) last_wb = 1'b0;
    end

    always_comb begin
        state_d          = state_q;
        issuing          = 1'b0;
        dp.dp_dir        = 1'b0;
        dp.dp_speed      = '0;
        dp.dp_boundary   = '0;
        dp.dp_currentPos = '0;
        case (state_q)
            IDLE:  if (frame_tick) state_d = ISSUE;
            ISSUE: begin
                issuing          = 1'b1;
                dp.dp_dir        = obj_dir[issue_idx];
                dp.dp_speed      = spd_a[issue_idx];
                dp.dp_boundary   = bnd_a[issue_idx];
                dp.dp_currentPos = pos_q[issue_idx];
                if (last_issue) state_d = DRAIN;
            end
            DRAIN: if (last_wb) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            issue_idx <= '0;
            vld_pipe  <= '0;
            idx_pipe  <= '0;
            bnd_pipe  <= '0;
            pos_q     <= {NUM_OBJ{INIT_POS}};
            hit_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issuing) issue_idx <= last_issue ? '0 : issue_idx + 1'b1;
            // Boundary is captured at issue so the hit test ignores later input changes.
            vld_pipe[1] <= issuing;
            idx_pipe[1] <= issue_idx;
            bnd_pipe[1] <= dp.dp_boundary;
            for (int i = 2; i <= PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
                bnd_pipe[i] <= bnd_pipe[i-1];
            end
            if (frame_tick && busy) overrun_q <= 1'b1;
            if (tick_idle) hit_q <= '0;
            if (vld_pipe[PIPE_LAT]) begin
                pos_q[idx_pipe[PIPE_LAT]] <= dp.dp_boundedNextPos;
                hit_q[idx_pipe[PIPE_LAT]] <= (dp.dp_boundedNextPos == bnd_pipe[PIPE_LAT]);
            end
`ifdef POS_SCHED_LOAD_EN
            if (load_valid && load_ready && (load_idx <= IDX_W'(NUM_OBJ - 1))) begin
                pos_q[load_idx] <= load_pos;
                hit_q[load_idx] <= 1'b0;
            end
`endif
        end
    end
endmodule
